// File: rtl/funct_arbiter.sv
// Round-robin arbiter sharing one funct instance among NB_REQ requesters, one transaction in flight.
// Latency: grant edge -> fct_en next cycle; rsp_valid one cycle after fct_done; TIMEOUT WAIT cycles abort.
// Backpressure: requesters hold req_valid until a one-hot req_ready pulse; results are pushed, not held.
module funct_arbiter #(
    parameter int NB_REQ    = 4,
    parameter int NB_INPUT  = 1,
    parameter int NB_OUTPUT = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NB_REQ-1:0]                      req_valid,
    input  logic [0:NB_REQ-1][0:NB_INPUT-1][31:0]  req_data,
    output logic [NB_REQ-1:0]                      req_ready,
    output logic [NB_REQ-1:0]                      rsp_valid,
    output logic [0:NB_OUTPUT-1][31:0]             rsp_data,
    output logic                                   fct_en,
    output logic [0:NB_INPUT-1][31:0]              fct_data,
    input  logic                                   fct_done,
    input  logic [0:NB_OUTPUT-1][31:0]             fct_result,
    output logic                                   busy,
    output logic                                   timeout_err,
    output logic [15:0]                            done_cnt
);

    localparam int IDW = $clog2(NB_REQ);
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                         state_q;
    logic [IDW-1:0]                 ptr_q;
    logic [IDW-1:0]                 id_q;
    logic [0:NB_INPUT-1][31:0]      hold_q;
    logic [0:NB_OUTPUT-1][31:0]     result_q;
    logic [CW-1:0]                  wcnt_q;
    logic [15:0]                    done_cnt_q;
    logic [NB_REQ-1:0]              req_ready_q;
    logic [NB_REQ-1:0]              rsp_valid_q;
    logic                           fct_en_q;
    logic                           timeout_err_q;
    logic                           busy_q;

    logic                           gnt_vld_d;
    logic [IDW-1:0]                 gnt_idx_d;
    logic [IDW-1:0]                 ptr_nxt_d;
    int                             scan_j;

    // Rotating priority search starting at ptr_q; first pending requester wins.
    always_comb begin
        gnt_vld_d = 1'b0;
        gnt_idx_d = '0;
        scan_j    = 0;
        for (int k = 0; k < NB_REQ; k++) begin
            scan_j = int'(ptr_q) + k;
            if (scan_j >= NB_REQ) begin
                scan_j = scan_j - NB_REQ;
            end
            if (!gnt_vld_d && req_valid[IDW'(scan_j)]) begin
                gnt_vld_d = 1'b1;
                gnt_idx_d = IDW'(scan_j);
            end
        end
    end

    // Pointer moves just past the requester that was served (or aborted).
    assign ptr_nxt_d = (id_q == IDW'(NB_REQ - 1)) ? '0 : id_q + IDW'(1);

    // Transaction FSM; all strobe outputs are registered for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            id_q          <= '0;
            hold_q        <= '0;
            result_q      <= '0;
            wcnt_q        <= '0;
            done_cnt_q    <= '0;
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            fct_en_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            fct_en_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld_d) begin
                        state_q     <= S_ISSUE;
                        id_q        <= gnt_idx_d;
                        hold_q      <= req_data[gnt_idx_d];
                        fct_en_q    <= 1'b1;
                        req_ready_q <= {{(NB_REQ-1){1'b0}}, 1'b1} << gnt_idx_d;
                        busy_q      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    wcnt_q  <= '0;
                end
                S_WAIT: begin
                    // Completion takes priority over the limit in the same cycle.
                    if (fct_done) begin
                        state_q     <= S_RESP;
                        result_q    <= fct_result;
                        rsp_valid_q <= {{(NB_REQ-1){1'b0}}, 1'b1} << id_q;
                    end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                        state_q       <= S_IDLE;
                        timeout_err_q <= 1'b1;
                        ptr_q         <= ptr_nxt_d;
                        busy_q        <= 1'b0;
                    end else begin
                        wcnt_q <= wcnt_q + CW'(1);
                    end
                end
                S_RESP: begin
                    state_q    <= S_IDLE;
                    ptr_q      <= ptr_nxt_d;
                    done_cnt_q <= done_cnt_q + 16'd1;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = (state_q == S_RESP) ? result_q : '0;
    assign fct_en      = fct_en_q;
    assign fct_data    = hold_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_funct_arbiter.sv
// Randomized bench for funct_arbiter with a transaction-level model and scoreboard.
// Stimulus and the funct stub run on the falling edge; the monitor samples 1 time unit after the rising edge.
// Expected events carry the rising-edge index at which they must appear.
module tb_funct_arbiter;
    localparam int NR = 4;
    localparam int NI = 2;
    localparam int NO = 1;
    localparam int TO = 8;
    localparam int K_ISS = 0;
    localparam int K_RSP = 1;
    localparam int K_TMO = 2;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NR-1:0]                req_valid;
    logic [0:NR-1][0:NI-1][31:0]  req_data;
    logic [NR-1:0]                req_ready;
    logic [NR-1:0]                rsp_valid;
    logic [0:NO-1][31:0]          rsp_data;
    logic                         fct_en;
    logic [0:NI-1][31:0]          fct_data;
    logic                         fct_done;
    logic [0:NO-1][31:0]          fct_result;
    logic                         busy;
    logic                         timeout_err;
    logic [15:0]                  done_cnt;

    funct_arbiter #(.NB_REQ(NR), .NB_INPUT(NI), .NB_OUTPUT(NO), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .fct_en(fct_en), .fct_data(fct_data), .fct_done(fct_done), .fct_result(fct_result),
        .busy(busy), .timeout_err(timeout_err), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          id;
        logic [63:0] dat;
        int          edge_n;
    } exp_t;

    exp_t        sb[$];
    int          glog[$];
    int          total = 0;
    int          bad = 0;
    int          ecnt = 0;
    int          busy_lo = 1, busy_hi = 0;
    int          wait_lo = 1, wait_hi = 0;
    int          free_edge = 0;
    int          mptr = 0, mdone = 0, ngrant = 0;
    int          next_lat = 3, cur_lat = 0;
    logic [63:0] exp_hold = '0;
    int          stub_cnt = 0;
    logic [31:0] stub_res = '0;
    bit          spur_en = 1'b0;
    exp_t        mon_e;
    logic [NR-1:0] mon_oh;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ecnt);
        end
    endtask

    // Monitor: counts rising edges and checks every cycle against the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            ecnt++;
            #1;
            chk("busy", {63'b0, busy}, {63'b0, (ecnt >= busy_lo && ecnt <= busy_hi)});
            chk("fct_data_hold", fct_data, exp_hold);
            if (rsp_valid == '0) chk("rsp_data_zero", {32'b0, rsp_data}, 64'd0);
            if (req_ready == '0) chk("fct_en_off", {63'b0, fct_en}, 64'd0);
            while (sb.size() > 0 && sb[0].edge_n < ecnt) begin
                chk("missed_evt_edge", ecnt, sb[0].edge_n);
                void'(sb.pop_front());
            end
            if (req_ready != '0 || rsp_valid != '0 || timeout_err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {55'b0, req_ready, rsp_valid, timeout_err}, 64'd0);
                end else begin
                    mon_e  = sb.pop_front();
                    mon_oh = NR'(1) << mon_e.id;
                    chk("evt_edge", ecnt, mon_e.edge_n);
                    if (mon_e.kind == K_ISS) begin
                        chk("iss_ready", {60'b0, req_ready}, {60'b0, mon_oh});
                        chk("iss_fct_en", {63'b0, fct_en}, 64'd1);
                        chk("iss_data", fct_data, mon_e.dat);
                        chk("iss_rsp", {60'b0, rsp_valid}, 64'd0);
                        chk("iss_tmo", {63'b0, timeout_err}, 64'd0);
                    end else if (mon_e.kind == K_RSP) begin
                        chk("rsp_valid", {60'b0, rsp_valid}, {60'b0, mon_oh});
                        chk("rsp_data", {32'b0, rsp_data}, mon_e.dat);
                        chk("rsp_ready", {60'b0, req_ready}, 64'd0);
                        chk("rsp_tmo", {63'b0, timeout_err}, 64'd0);
                    end else begin
                        chk("tmo_err", {63'b0, timeout_err}, 64'd1);
                        chk("tmo_rsp", {60'b0, rsp_valid}, 64'd0);
                        chk("tmo_ready", {60'b0, req_ready}, 64'd0);
                    end
                end
            end
        end
    end

    // Reference model: decides what the coming rising edge does, from the inputs now on the pins.
    task automatic model_step();
        int u;
        int g;
        int j;
        int lat;
        logic [31:0] r;
        u = ecnt + 1;
        if (rst) begin
            sb.delete();
            busy_lo = 1; busy_hi = 0;
            wait_lo = 1; wait_hi = 0;
            exp_hold = '0;
            mptr = 0;
            mdone = 0;
            free_edge = u + 1;
        end else if (u >= free_edge && req_valid != '0) begin
            g = -1;
            for (int k = 0; k < NR; k++) begin
                j = (mptr + k) % NR;
                if (g < 0 && req_valid[j]) g = j;
            end
            lat = next_lat;
            cur_lat = lat;
            r = req_data[g][0] + req_data[g][1] + 32'd1;
            sb.push_back('{K_ISS, g, 64'(req_data[g]), u});
            exp_hold = req_data[g];
            busy_lo = u;
            wait_lo = u + 1;
            if (lat >= 1 && lat <= TO) begin
                sb.push_back('{K_RSP, g, {32'b0, r}, u + lat + 1});
                busy_hi = u + lat + 1;
                wait_hi = u + lat;
                mdone++;
            end else begin
                sb.push_back('{K_TMO, g, 64'd0, u + TO + 1});
                busy_hi = u + TO;
                wait_hi = u + TO;
            end
            free_edge = busy_hi + 2;
            mptr = (g + 1) % NR;
            ngrant++;
            glog.push_back(g);
        end
    endtask

    // funct stub: result = word0 + word1 + 1, delivered cur_lat cycles after fct_en (0 = never).
    task automatic stub_step();
        bit d;
        bit spur;
        d = 1'b0;
        if (fct_en) begin
            stub_cnt = cur_lat;
            stub_res = fct_data[0] + fct_data[1] + 32'd1;
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) d = 1'b1;
        end
        spur = spur_en && !(ecnt >= wait_lo && ecnt <= wait_hi) && ($urandom_range(0, 5) == 0);
        fct_done = d | spur;
        fct_result[0] = d ? stub_res : $urandom;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        stub_step();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(ecnt + 1 >= free_edge && sb.size() == 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("idle_wait_expired", n, 0);
    endtask

    task automatic one_req(input logic [NR-1:0] v, input int lat);
        req_valid = v;
        next_lat = lat;
        tick();
        req_valid = '0;
        wait_idle();
    endtask

    initial begin
        int n;
        int g0;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        fct_done = 1'b0;
        fct_result = '0;
        tick();
        repeat (2) tick();
        rst = 1'b0;
        chk("done_cnt_reset", done_cnt, 64'(mdone));

        // Single request, 3-cycle funct, 7 -> 8.
        req_data[1][0] = 32'h7;
        one_req(4'b0010, 3);
        chk("done_cnt_single", done_cnt, 64'(mdone));

        // Timeout, then pointer has advanced past the aborted requester.
        req_data[0] = {32'h11, 32'h22};
        one_req(4'b0001, 0);
        req_data[1] = {32'h100, 32'h5};
        one_req(4'b0011, 3);
        // Completion in the last allowed WAIT cycle, then one cycle too late.
        req_data[2] = {32'hA, 32'hB};
        one_req(4'b0100, TO);
        one_req(4'b0100, TO + 1);
        chk("done_cnt_tmo", done_cnt, 64'(mdone));

        // Reset during WAIT abandons the transaction.
        req_data[3] = {32'h55, 32'h66};
        req_valid = 4'b1000;
        next_lat = 6;
        tick();
        req_valid = '0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        spur_en = 1'b1;
        repeat (12) tick();
        spur_en = 1'b0;
        chk("done_cnt_after_rst", done_cnt, 64'(mdone));

        // All four held high: round-robin order from pointer 0.
        glog.delete();
        for (int i = 0; i < NR; i++) req_data[i] = {32'(i * 16), 32'h1};
        req_valid = 4'b1111;
        next_lat = 3;
        g0 = ngrant;
        n = 0;
        while (ngrant - g0 < 5 && n < 200) begin
            tick();
            n++;
        end
        req_valid = '0;
        wait_idle();
        for (int i = 0; i < 5; i++) chk("rr_order", 64'(glog[i]), 64'(i % NR));
        chk("done_cnt_rr", done_cnt, 64'(mdone));

        // Randomized traffic with spurious fct_done outside WAIT and data churn while busy.
        spur_en = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                req_valid = NR'($urandom);
                for (int i = 0; i < NR; i++) req_data[i] = {$urandom, $urandom};
            end
            next_lat = $urandom_range(0, 10);
            tick();
        end
        req_valid = '0;
        wait_idle();
        chk("done_cnt_random", done_cnt, 64'(mdone & 16'hFFFF));

        // Spurious fct_done while idle must change nothing.
        repeat (30) tick();
        spur_en = 1'b0;
        repeat (3) tick();
        chk("done_cnt_final", done_cnt, 64'(mdone & 16'hFFFF));
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/funct_arbiter.md
FUNCT_ARBITER -- requirements
Module: funct_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning); all SHALL be honoured:
- NB_REQ, 4, number of requesters, 2..16.
- NB_INPUT, 1, 32-bit words per request frame.
- NB_OUTPUT, 1, 32-bit words per result frame.
- TIMEOUT, 64, maximum WAIT cycles before abort, >=2.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NB_REQ  requester i has a frame pending.
- req_data  in  NB_REQ x NB_INPUT x 32  request frames, packed [0:NB_REQ-1][0:NB_INPUT-1][31:0].
- req_ready  out  NB_REQ  one-hot, 1-cycle pulse: frame i consumed.
- rsp_valid  out  NB_REQ  one-hot, 1-cycle pulse: result for requester i.
- rsp_data  out  NB_OUTPUT x 32  result frame, valid only while rsp_valid != 0, else 0.
- fct_en  out  1  drives the in_en_fct input of the shared funct instance.
- fct_data  out  NB_INPUT x 32  drives in_data_fct.
- fct_done  in  1  from out_en_fct.
- fct_result  in  NB_OUTPUT x 32  from out_data_fct.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  1-cycle pulse on an aborted transaction.
- done_cnt  out  16  completed-transaction count, wraps 0xFFFF->0.

Function
REQ-003 Four-state FSM, SHALL follow these transitions:
- IDLE->ISSUE: any req_valid high at the clock edge.
- ISSUE->WAIT: always, after one cycle.
- WAIT->RESP: fct_done high.
- WAIT->IDLE: timeout.
- RESP->IDLE: always, after one cycle.
REQ-004 Grant (at IDLE edge): first i with req_valid[i]=1, searching ptr, ptr+1, ..., NB_REQ-1, 0, ..., ptr-1; capture id<=i and hold<=req_data[i] on the same edge.
REQ-005 ISSUE, exactly one cycle: fct_en=1, fct_data=hold, req_ready[id]=1; all other outputs inactive.
REQ-006 fct_data SHALL equal hold in every state; fct_en SHALL be 0 outside ISSUE.
REQ-007 WAIT: wait counter cleared on entry, +1 per WAIT cycle; fct_done sampled high -> result<=fct_result, go RESP.
REQ-008 Timeout: TIMEOUT WAIT cycles without fct_done -> timeout_err=1 for the cycle after the last WAIT cycle, go IDLE, no rsp_valid.
REQ-009 If fct_done arrives in the same cycle the limit is reached, completion SHALL win: RESP, no timeout_err.
REQ-010 RESP, exactly one cycle: rsp_valid[id]=1, rsp_data=result, done_cnt+=1.
REQ-011 On leaving RESP or on timeout, ptr <= (id+1) mod NB_REQ; ptr unchanged otherwise.
REQ-012 fct_done outside WAIT SHALL be ignored: no state change, result unchanged.
REQ-013 req_valid and req_data are sampled only at the IDLE edge; changes during ISSUE, WAIT or RESP SHALL have no effect.
REQ-014 A requester still holding req_valid after its req_ready is a new request, arbitrated normally at the next IDLE.
REQ-015 Throughput: one transaction in flight; minimum IDLE->IDLE loop is IDLE, ISSUE, WAIT (>=1 cycle), RESP.
REQ-016 Latency with funct (3-cycle turnaround): req_valid sampled at edge k -> fct_en in cycle k+1 -> fct_done in cycle k+4 -> rsp_valid in cycle k+5.
REQ-017 All outputs SHALL be decoded from registered state and registers; no combinational input-to-output path.

Reset
REQ-018 rst=1 at an edge SHALL force: state IDLE, ptr=0, id=0, hold=0, result=0, wait counter=0, done_cnt=0.
REQ-019 During and after reset, all outputs SHALL be 0 until the next grant.
REQ-020 Reset mid-transaction SHALL abandon it: no rsp_valid, no timeout_err; any late fct_done is ignored per REQ-012.

Verification
REQ-021 Single request: req_valid=0010, req_data[1]=0x00000007, funct attached -> fct_en in cycle k+1 with data 7; req_ready=0010 in cycle k+1; rsp_valid=0010 with rsp_data=0x00000008 in cycle k+5; done_cnt=1.
REQ-022 Round-robin fairness: all four req_valid held high continuously -> grant order 0,1,2,3,0; every response carries the correct id; done_cnt=5.
REQ-023 Timeout: funct stubbed to never assert fct_done, TIMEOUT=8 -> timeout_err pulse exactly 8 WAIT cycles after ISSUE; no rsp_valid; ptr advances; next request is granted normally.
REQ-024 Tie at limit: fct_done driven in the 8th WAIT cycle with TIMEOUT=8 -> rsp_valid asserted, timeout_err stays 0.
REQ-025 Reset mid-WAIT: rst pulsed 1 cycle during WAIT, then stub asserts fct_done -> no rsp_valid, busy=0, done_cnt=0, ptr=0.
REQ-026 Wrap and spurious input: preload done_cnt=0xFFFF by 65535 transactions -> wraps to 0; fct_done pulsed while IDLE -> no outputs change.
